// File: rtl/set_pkg.sv
// Shared types and the width-safe squared-distance helper for the set counters.
package set_pkg;

  typedef enum logic [1:0] {
    SET_A   = 2'd0,
    SET_AND = 2'd1,
    SET_OR  = 2'd2,
    SET_XOR = 2'd3
  } set_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } set_state_t;

  // Coordinates are zero-extended to SQ_IN_W before the distance is formed,
  // so one helper serves every COORD_W up to SQ_IN_W without truncation.
  localparam int SQ_IN_W  = 16;
  localparam int SQ_OUT_W = 2 * SQ_IN_W + 1;

  // (px-cx)^2 + (py-cy)^2 with a signed difference one bit wider than the
  // operands, unsigned squares, and a sum one bit wider than a square.
  function automatic logic [SQ_OUT_W-1:0] sq_dist(input logic [SQ_IN_W-1:0] px,
                                                  input logic [SQ_IN_W-1:0] py,
                                                  input logic [SQ_IN_W-1:0] cx,
                                                  input logic [SQ_IN_W-1:0] cy);
    logic signed [SQ_IN_W:0] dx;
    logic signed [SQ_IN_W:0] dy;
    logic [SQ_IN_W-1:0]      ax;
    logic [SQ_IN_W-1:0]      ay;
    logic [2*SQ_IN_W-1:0]    sx;
    logic [2*SQ_IN_W-1:0]    sy;
    dx = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy = $signed({1'b0, py}) - $signed({1'b0, cy});
    ax = dx[SQ_IN_W] ? SQ_IN_W'(-dx) : SQ_IN_W'(dx);
    ay = dy[SQ_IN_W] ? SQ_IN_W'(-dy) : SQ_IN_W'(dy);
    sx = {{SQ_IN_W{1'b0}}, ax} * {{SQ_IN_W{1'b0}}, ax};
    sy = {{SQ_IN_W{1'b0}}, ay} * {{SQ_IN_W{1'b0}}, ay};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/set_lane_eval.sv
// One evaluation lane: tests a single grid point against circles A and B and
// combines the two memberships according to the registered mode.
module set_lane_eval
  import set_pkg::*;
#(
  parameter int PT_W    = 5,
  parameter int COORD_W = 4,
  parameter int RAD_W   = 4
) (
  input  logic [PT_W-1:0]      px_i,
  input  logic [PT_W-1:0]      py_i,
  input  logic [1:0]           mode_i,
  input  logic [2*COORD_W-1:0] central_a_i,
  input  logic [RAD_W-1:0]     radius_a_i,
  input  logic [2*COORD_W-1:0] central_b_i,
  input  logic [RAD_W-1:0]     radius_b_i,
  output logic                 hit_o
);

  localparam int CMP_W = (2 * RAD_W > SQ_OUT_W) ? 2 * RAD_W : SQ_OUT_W;

  logic [2*RAD_W-1:0] ra2;
  logic [2*RAD_W-1:0] rb2;
  logic [CMP_W-1:0]   da;
  logic [CMP_W-1:0]   db;
  logic               in_a;
  logic               in_b;

  // Membership of the point in each circle (boundary inclusive), then the set operation.
  always_comb begin
    ra2  = {{RAD_W{1'b0}}, radius_a_i} * {{RAD_W{1'b0}}, radius_a_i};
    rb2  = {{RAD_W{1'b0}}, radius_b_i} * {{RAD_W{1'b0}}, radius_b_i};
    da   = CMP_W'(sq_dist(SQ_IN_W'(px_i), SQ_IN_W'(py_i),
                          SQ_IN_W'(central_a_i[2*COORD_W-1:COORD_W]),
                          SQ_IN_W'(central_a_i[COORD_W-1:0])));
    db   = CMP_W'(sq_dist(SQ_IN_W'(px_i), SQ_IN_W'(py_i),
                          SQ_IN_W'(central_b_i[2*COORD_W-1:COORD_W]),
                          SQ_IN_W'(central_b_i[COORD_W-1:0])));
    in_a = (da <= CMP_W'(ra2));
    in_b = (db <= CMP_W'(rb2));
    hit_o = in_a;
    case (set_mode_t'(mode_i))
      SET_A:   hit_o = in_a;
      SET_AND: hit_o = in_a & in_b;
      SET_OR:  hit_o = in_a | in_b;
      SET_XOR: hit_o = in_a ^ in_b;
      default: hit_o = in_a;
    endcase
  end

endmodule

// File: rtl/set_counter_mc.sv
// Counts grid points inside a two-circle set expression, LANES points per cycle.
//
// Handshake: en is a start strobe sampled only while busy=0. The accepting
// edge captures every other input and raises busy. busy stays high through
// the scan and the single result cycle; valid is high for exactly that one
// result cycle, and candidate holds the count until the next result cycle.
module set_counter_mc
  import set_pkg::*;
#(
  parameter int GRID_N  = 8,
  parameter int COORD_W = 4,
  parameter int RAD_W   = 4,
  parameter int LANES   = 1,
  parameter int CNT_W   = $clog2(GRID_N * GRID_N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [2*COORD_W-1:0] central_a,
  input  logic [RAD_W-1:0]     radius_a,
  input  logic [2*COORD_W-1:0] central_b,
  input  logic [RAD_W-1:0]     radius_b,
  output logic                 busy,
  output logic                 valid,
  output logic [CNT_W-1:0]     candidate,
  output logic [1:0]           dbg_state
);

  localparam int PT_W  = $clog2(GRID_N + 1) + 1;
  localparam int SUM_W = $clog2(LANES + 1);
  localparam logic [PT_W-1:0] X_LAST = PT_W'(GRID_N - LANES + 1);
  localparam logic [PT_W-1:0] Y_LAST = PT_W'(GRID_N);

  set_state_t           state_q, state_d;
  logic [1:0]           mode_q;
  logic [2*COORD_W-1:0] ca_q, cb_q;
  logic [RAD_W-1:0]     ra_q, rb_q;
  logic [PT_W-1:0]      x_q, y_q;
  logic [CNT_W-1:0]     acc_q, cand_q;

  logic [LANES-1:0]     hits;
  logic [SUM_W-1:0]     lane_sum;
  logic [CNT_W-1:0]     acc_d;
  logic                 last_scan;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    set_lane_eval #(
      .PT_W    (PT_W),
      .COORD_W (COORD_W),
      .RAD_W   (RAD_W)
    ) u_lane (
      .px_i        (x_q + PT_W'(l)),
      .py_i        (y_q),
      .mode_i      (mode_q),
      .central_a_i (ca_q),
      .radius_a_i  (ra_q),
      .central_b_i (cb_q),
      .radius_b_i  (rb_q),
      .hit_o       (hits[l])
    );
  end

  // Population count of this cycle's lane hits added to the running total.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + SUM_W'(hits[l]);
    end
    acc_d     = acc_q + CNT_W'(lane_sum);
    last_scan = (x_q == X_LAST) && (y_q == Y_LAST);
  end

  // Next-state logic and outputs decoded from the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = SCAN;
      SCAN:    if (last_scan) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy      = (state_q != IDLE);
    valid     = (state_q == DONE);
    candidate = cand_q;
    dbg_state = state_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture, scan position, accumulator and held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= '0;
      ca_q   <= '0;
      ra_q   <= '0;
      cb_q   <= '0;
      rb_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cand_q <= '0;
    end else begin
      if (state_q == IDLE && en) begin
        mode_q <= mode;
        ca_q   <= central_a;
        ra_q   <= radius_a;
        cb_q   <= central_b;
        rb_q   <= radius_b;
        x_q    <= PT_W'(1);
        y_q    <= PT_W'(1);
        acc_q  <= '0;
      end else if (state_q == SCAN) begin
        acc_q <= acc_d;
        if (x_q == X_LAST) begin
          x_q <= PT_W'(1);
          y_q <= y_q + PT_W'(1);
        end else begin
          x_q <= x_q + PT_W'(LANES);
        end
        if (last_scan) cand_q <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_set_counter_mc.sv
// Directed and randomized checks of set_counter_mc at LANES=1 and LANES=4.
module tb_set_counter_mc;

  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          en1, en4;
  logic [1:0]    mode;
  logic [7:0]    central_a, central_b;
  logic [3:0]    radius_a, radius_b;

  logic          busy1, valid1, busy4, valid4;
  logic [CW-1:0] cand1, cand4;
  logic [1:0]    st1, st4;

  logic          sel4;
  logic          o_busy, o_valid;
  logic [CW-1:0] o_cand;
  logic [CW-1:0] last_cand [2];

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  set_counter_mc #(.GRID_N(8), .COORD_W(4), .RAD_W(4), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode),
    .central_a(central_a), .radius_a(radius_a),
    .central_b(central_b), .radius_b(radius_b),
    .busy(busy1), .valid(valid1), .candidate(cand1), .dbg_state(st1)
  );

  set_counter_mc #(.GRID_N(8), .COORD_W(4), .RAD_W(4), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode),
    .central_a(central_a), .radius_a(radius_a),
    .central_b(central_b), .radius_b(radius_b),
    .busy(busy4), .valid(valid4), .candidate(cand4), .dbg_state(st4)
  );

  // Observe whichever instance is currently under test.
  always_comb begin
    o_busy  = sel4 ? busy4 : busy1;
    o_valid = sel4 ? valid4 : valid1;
    o_cand  = sel4 ? cand4 : cand1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference: brute-force count over the grid with integer geometry.
  function automatic int model(input int m, input int ax, input int ay, input int ra,
                               input int bx, input int by, input int rb);
    int n = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        bit ia, ib, h;
        ia = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= ra * ra;
        ib = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= rb * rb;
        case (m)
          0: h = ia;
          1: h = ia & ib;
          2: h = ia | ib;
          default: h = ia ^ ib;
        endcase
        if (h) n++;
      end
    end
    return n;
  endfunction

  // Present an operation at a negedge in IDLE; returns right after the accepting edge.
  task automatic issue(input bit use4, input int m, input int ax, input int ay, input int ra,
                       input int bx, input int by, input int rb);
    @(negedge clk);
    sel4 = use4;
    check("busy_low_before_start", 32'(o_busy), 0);
    mode      = 2'(m);
    central_a = {4'(ax), 4'(ay)};
    radius_a  = 4'(ra);
    central_b = {4'(bx), 4'(by)};
    radius_b  = 4'(rb);
    if (use4) en4 = 1'b1;
    else      en1 = 1'b1;
    @(posedge clk);
  endtask

  // Follow one operation cycle by cycle after the accepting edge.
  task automatic wait_result(input int exp_cnt, input int exp_lat, input bit drop_en,
                             input int poke_k, input int rst_k, input bit scramble);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1 && drop_en) begin
        en1 = 1'b0;
        en4 = 1'b0;
      end
      if (k == 1 && scramble) begin
        central_a = 8'($urandom);
        radius_a  = 4'($urandom);
        central_b = 8'($urandom);
        radius_b  = 4'($urandom);
        mode      = 2'($urandom);
      end
      if (poke_k > 0 && k == poke_k) begin
        central_a = {4'd1, 4'd1};
        radius_a  = 4'd7;
        if (sel4) en4 = 1'b1;
        else      en1 = 1'b1;
      end
      if (poke_k > 0 && k == poke_k + 1) begin
        en1 = 1'b0;
        en4 = 1'b0;
      end
      if (rst_k > 0 && k == rst_k) begin
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_candidate", 32'(o_cand), 0);
        last_cand[0] = '0;
        last_cand[1] = '0;
        @(negedge clk);
        check("rst_no_valid", 32'(o_valid), 0);
        rst = 1'b1;
        return;
      end
      if (o_valid) begin
        seen = 1;
        check("latency", k, exp_lat);
        check("candidate", 32'(o_cand), exp_cnt);
        check("busy_with_valid", 32'(o_busy), 1);
        last_cand[sel4] = CW'(exp_cnt);
      end else begin
        check("busy_during_scan", 32'(o_busy), 1);
        check("candidate_held", 32'(o_cand), 32'(last_cand[sel4]));
      end
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  // Release a held en in the IDLE cycle that follows a result.
  task automatic stop_en();
    @(negedge clk);
    check("busy_low_after_valid", 32'(o_busy), 0);
    en1 = 1'b0;
    en4 = 1'b0;
  endtask

  initial begin
    int m, ax, ay, ra, bx, by, rb;
    bit u4;
    rst = 1'b0; en1 = 1'b0; en4 = 1'b0; sel4 = 1'b0;
    mode = '0; central_a = '0; radius_a = '0; central_b = '0; radius_b = '0;
    last_cand[0] = '0;
    last_cand[1] = '0;

    repeat (2) @(negedge clk);
    check("reset_busy1", 32'(busy1), 0);
    check("reset_valid1", 32'(valid1), 0);
    check("reset_cand1", 32'(cand1), 0);
    check("reset_state1", 32'(st1), 0);
    check("reset_busy4", 32'(busy4), 0);
    check("reset_cand4", 32'(cand4), 0);
    rst = 1'b1;

    // Single circle, interior, boundary counted
    issue(0, 0, 4, 4, 2, 9, 9, 9);
    wait_result(13, 65, 1, 0, 0, 0);
    stop_en();

    // Zero radius on-grid, off-grid; radius covering the whole grid
    issue(0, 0, 1, 1, 0, 0, 0, 0);
    wait_result(1, 65, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    wait_result(0, 65, 1, 0, 0, 0);
    issue(0, 0, 4, 4, 15, 0, 0, 0);
    wait_result(64, 65, 1, 0, 0, 0);

    // Two circles, en held high across three back-to-back operations
    issue(0, 1, 3, 4, 2, 5, 4, 2);
    wait_result(5, 65, 0, 0, 0, 0);
    issue(0, 2, 3, 4, 2, 5, 4, 2);
    wait_result(21, 65, 0, 0, 0, 0);
    issue(0, 3, 3, 4, 2, 5, 4, 2);
    wait_result(16, 65, 0, 0, 0, 0);
    stop_en();

    // en pulsed during SCAN with a different A is ignored
    issue(0, 0, 4, 4, 2, 0, 0, 0);
    wait_result(13, 65, 1, 10, 0, 0);
    // reset in the middle of a scan, then a clean run
    issue(0, 0, 4, 4, 3, 0, 0, 0);
    wait_result(0, 65, 1, 0, 30, 0);
    issue(0, 0, 4, 4, 2, 0, 0, 0);
    wait_result(13, 65, 1, 0, 0, 0);

    // Inputs change right after the accepting edge
    issue(0, 0, 4, 4, 2, 0, 0, 0);
    wait_result(13, 65, 1, 0, 0, 1);

    // Four-lane instance: same counts, shorter latency
    issue(1, 0, 4, 4, 2, 9, 9, 9);
    wait_result(13, 17, 1, 0, 0, 0);
    issue(1, 1, 3, 4, 2, 5, 4, 2);
    wait_result(5, 17, 0, 0, 0, 0);
    issue(1, 2, 3, 4, 2, 5, 4, 2);
    wait_result(21, 17, 0, 0, 0, 0);
    issue(1, 3, 3, 4, 2, 5, 4, 2);
    wait_result(16, 17, 0, 0, 0, 0);
    stop_en();

    // Randomized operations against the reference model
    for (int i = 0; i < 14; i++) begin
      u4 = i[0];
      m  = $urandom_range(0, 3);
      ax = $urandom_range(0, 15);
      ay = $urandom_range(0, 15);
      ra = $urandom_range(0, 15);
      bx = $urandom_range(0, 15);
      by = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      issue(u4, m, ax, ay, ra, bx, by, rb);
      wait_result(model(m, ax, ay, ra, bx, by, rb), u4 ? 17 : 65, 1, 0, 0, 0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
